ps2_rx: RTL and testbench

PS/2 keyboard line receiver for the x86 keyboard path. Samples the open-collector PS/2 clock and data lines, deframes 11-bit device-to-host frames, checks parity and stop bit, and buffers received scancodes in a 4-entry FIFO. Bytes are delivered over a valid/ready handshake compatible with the keyboard controller's push port (`r_valid`/`r_ready`, byte on `r_din[7:0]`). The receiver inhibits the device by holding PS/2 clock low while its FIFO is full.

---
 rtl/ps2_rx.sv | 182 ++++++++++++++++++
 tb/tb_ps2_rx.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronizes and filters the pad lines, deframes
// 11-bit frames, and queues good bytes in a 4-entry FIFO behind a valid/ready port.
module ps2_rx #(
  parameter int unsigned FILTER      = 8,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  input  logic       err_clr,
  output logic       err_parity,
  output logic       err_frame,
  output logic       err_overrun
);

  localparam int unsigned FW = $clog2(FILTER + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  logic [1:0]    ck_sync_q, dt_sync_q;
  logic [FW-1:0] ck_cnt_q, ck_cnt_d, dt_cnt_q, dt_cnt_d;
  logic          ck_filt_q, ck_filt_d, dt_filt_q, dt_filt_d, ck_prev_q;
  logic          fall;

  state_e        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          push, set_par, set_frm;

  logic [7:0]    mem_q [4];
  logic [1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [2:0]    count_q, count_d;
  logic          valid_q, valid_d, oe_q, oe_d;
  logic [7:0]    data_q, data_d;
  logic          err_par_q, err_par_d, err_frm_q, err_frm_d, err_ovr_q, err_ovr_d;
  logic          full, push_ok, pop;

  // Level only flips after FILTER consecutive samples disagree with it.
  always_comb begin
    ck_cnt_d  = '0;
    ck_filt_d = ck_filt_q;
    dt_cnt_d  = '0;
    dt_filt_d = dt_filt_q;
    if (ck_sync_q[1] != ck_filt_q) begin
      if (ck_cnt_q == FW'(FILTER - 1)) ck_filt_d = ck_sync_q[1];
      else                             ck_cnt_d  = ck_cnt_q + FW'(1);
    end
    if (dt_sync_q[1] != dt_filt_q) begin
      if (dt_cnt_q == FW'(FILTER - 1)) dt_filt_d = dt_sync_q[1];
      else                             dt_cnt_d  = dt_cnt_q + FW'(1);
    end
  end

  assign fall = ck_prev_q & ~ck_filt_q;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    push      = 1'b0;
    set_par   = 1'b0;
    set_frm   = 1'b0;
    tmo_d     = (fall || state_q == StIdle) ? '0 : tmo_q + TW'(1);
    unique case (state_q)
      StIdle: if (fall && !dt_filt_q) begin
        state_d   = StData;
        bit_cnt_d = '0;
        shift_d   = '0;
      end
      StData: if (fall) begin
        shift_d[bit_cnt_q] = dt_filt_q;
        bit_cnt_d          = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) state_d = StParity;
      end
      StParity: if (fall) begin
        par_d   = dt_filt_q;
        state_d = StStop;
      end
      StStop: if (fall) begin
        state_d = StIdle;
        if (!(^{shift_q, par_q})) set_par = 1'b1;
        else if (!dt_filt_q)      set_frm = 1'b1;
        else                      push    = 1'b1;
      end
      default: state_d = StIdle;
    endcase
    if (state_q != StIdle && !fall && tmo_q == TW'(TIMEOUT_CYC - 1)) begin
      state_d = StIdle;
      set_frm = 1'b1;
    end
  end

  assign full    = (count_q == 3'd4);
  assign push_ok = push & ~full;
  assign pop     = valid_q & out_ready;

  always_comb begin
    wptr_d  = wptr_q + 2'(push_ok);
    rptr_d  = rptr_q + 2'(pop);
    count_d = count_q;
    if (push_ok && !pop)      count_d = count_q + 3'd1;
    else if (!push_ok && pop) count_d = count_q - 3'd1;
    // Gate on out_ready so a trailing ready cannot accept the next byte.
    valid_d = (count_q != 3'd0) && !out_ready;
    data_d  = valid_d ? mem_q[rptr_q] : data_q;
    oe_d    = oe_q;
    if (full && state_q == StIdle) oe_d = 1'b1;
    else if (!full)                oe_d = 1'b0;
    err_par_d = set_par | (err_par_q & ~err_clr);
    err_frm_d = set_frm | (err_frm_q & ~err_clr);
    err_ovr_d = (push & full) | (err_ovr_q & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= shift_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ck_sync_q <= 2'b11;
      dt_sync_q <= 2'b11;
      ck_cnt_q  <= '0;
      dt_cnt_q  <= '0;
      ck_filt_q <= 1'b1;
      dt_filt_q <= 1'b1;
      ck_prev_q <= 1'b1;
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      tmo_q     <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      oe_q      <= 1'b0;
      err_par_q <= 1'b0;
      err_frm_q <= 1'b0;
      err_ovr_q <= 1'b0;
    end else begin
      ck_sync_q <= {ck_sync_q[0], ps2_clk_in};
      dt_sync_q <= {dt_sync_q[0], ps2_data_in};
      ck_cnt_q  <= ck_cnt_d;
      dt_cnt_q  <= dt_cnt_d;
      ck_filt_q <= ck_filt_d;
      dt_filt_q <= dt_filt_d;
      ck_prev_q <= ck_filt_q;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      tmo_q     <= tmo_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      oe_q      <= oe_d;
      err_par_q <= err_par_d;
      err_frm_q <= err_frm_d;
      err_ovr_q <= err_ovr_d;
    end
  end

  assign ps2_clk_oe  = oe_q;
  assign out_data    = data_q;
  assign out_valid   = valid_q;
  assign err_parity  = err_par_q;
  assign err_frame   = err_frm_q;
  assign err_overrun = err_ovr_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Bench for ps2_rx: drives PS/2 frames bit by bit and checks delivered bytes and
// sticky flags against a queue-based model of the frame rules.
module tb_ps2_rx;

  localparam int unsigned FILT = 8;
  localparam int unsigned TMO  = 1000;
  localparam int          H    = 20;

  logic       clk = 1'b0;
  logic       reset_n, ps2_clk_in, ps2_data_in, out_ready, err_clr;
  logic       ps2_clk_oe, out_valid, err_parity, err_frame, err_overrun;
  logic [7:0] out_data;

  int tests_run = 0;
  int fails = 0;

  logic [7:0] exp_q[$];
  logic       m_par = 1'b0, m_frm = 1'b0, m_ovr = 1'b0;

  ps2_rx #(.FILTER(FILT), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .err_clr(err_clr), .err_parity(err_parity),
    .err_frame(err_frame), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  function automatic logic odd_par(input logic [7:0] b);
    return ~^b;
  endfunction

  // Frame rules applied to whole frames; consumer never pops mid-frame here.
  function automatic void model_frame(input logic [7:0] b, input logic par, input logic stop);
    if ((^{b, par}) == 1'b0)   m_par = 1'b1;
    else if (!stop)            m_frm = 1'b1;
    else if (exp_q.size() == 4) m_ovr = 1'b1;
    else                       exp_q.push_back(b);
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [10:0] bits, input int nbits, input int glitch_bit);
    for (int i = 0; i < nbits; i++) begin
      ps2_data_in = bits[i];
      wait_cyc(H);
      ps2_clk_in = 1'b0;
      wait_cyc(H);
      ps2_clk_in = 1'b1;
      if (i == glitch_bit) begin
        wait_cyc(15);
        ps2_clk_in = 1'b0;
        wait_cyc(FILT - 1);
        ps2_clk_in = 1'b1;
      end
    end
    ps2_data_in = 1'b1;
    wait_cyc(H);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                            input int glitch_bit);
    send_bits({stop, par, b, 1'b0}, 11, glitch_bit);
    model_frame(b, par, stop);
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    wait_cyc(1);
    err_clr = 1'b0;
    m_par = 1'b0; m_frm = 1'b0; m_ovr = 1'b0;
    wait_cyc(1);
  endtask

  // Consumer with a registered ready: ready stays high one cycle past acceptance.
  task automatic consume(output logic [7:0] b, output logic got, output logic trail_v);
    int n = 0;
    got = 1'b0; b = '0; trail_v = 1'b0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (out_valid) begin
      got = 1'b1;
      b = out_data;
      out_ready = 1'b1;
      @(negedge clk);
      trail_v = out_valid;
      @(negedge clk);
      trail_v = trail_v | out_valid;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    wait_cyc(3);
    tests_run += 6;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
    if (out_data !== 8'h00) begin fails++; $display("FAIL rst_data: got %h expected 00", out_data); end
    if (ps2_clk_oe !== 1'b0) begin fails++; $display("FAIL rst_oe: got %b expected 0", ps2_clk_oe); end
    if (err_parity !== 1'b0) begin fails++; $display("FAIL rst_par: got %b expected 0", err_parity); end
    if (err_frame !== 1'b0) begin fails++; $display("FAIL rst_frm: got %b expected 0", err_frame); end
    if (err_overrun !== 1'b0) begin fails++; $display("FAIL rst_ovr: got %b expected 0", err_overrun); end
    reset_n = 1'b1;
    wait_cyc(2);
  endtask

  task automatic test_frame_ok();
    logic [7:0] b, e;
    logic got, tv;
    send_frame(8'h1C, 1'b0, 1'b1, -1);
    tests_run += 2;
    if (out_valid !== 1'b1) begin fails++; $display("FAIL ok_valid: got %b expected 1", out_valid); end
    if (out_data !== 8'h1C) begin fails++; $display("FAIL ok_data: got %h expected 1c", out_data); end
    consume(b, got, tv);
    e = exp_q.pop_front();
    wait_cyc(10);
    tests_run += 5;
    if (got !== 1'b1 || b !== e) begin fails++; $display("FAIL ok_pop: got %h/%b expected %h/1", b, got, e); end
    if (tv !== 1'b0) begin fails++; $display("FAIL ok_trail: got %b expected 0", tv); end
    if (out_valid !== 1'b0) begin fails++; $display("FAIL ok_empty: got %b expected 0", out_valid); end
    if (err_parity !== m_par) begin fails++; $display("FAIL ok_par: got %b expected %b", err_parity, m_par); end
    if (err_frame !== m_frm) begin fails++; $display("FAIL ok_frm: got %b expected %b", err_frame, m_frm); end
  endtask

  task automatic test_parity_err();
    send_frame(8'h1C, 1'b1, 1'b1, -1);
    tests_run += 2;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL par_nopush: got %b expected 0", out_valid); end
    if (err_parity !== m_par) begin fails++; $display("FAIL par_set: got %b expected %b", err_parity, m_par); end
    clear_errs();
    tests_run++;
    if (err_parity !== 1'b0) begin fails++; $display("FAIL par_clr: got %b expected 0", err_parity); end
  endtask

  task automatic test_timeout();
    logic [7:0] b, e;
    logic got, tv;
    send_bits(11'b000_0000_0110, 4, -1);
    wait_cyc(TMO + 50);
    m_frm = 1'b1;
    tests_run += 2;
    if (err_frame !== m_frm) begin fails++; $display("FAIL tmo_frm: got %b expected %b", err_frame, m_frm); end
    if (out_valid !== 1'b0) begin fails++; $display("FAIL tmo_valid: got %b expected 0", out_valid); end
    clear_errs();
    send_frame(8'hF0, 1'b1, 1'b1, -1);
    consume(b, got, tv);
    e = exp_q.pop_front();
    tests_run += 2;
    if (got !== 1'b1 || b !== e) begin fails++; $display("FAIL tmo_next: got %h/%b expected %h/1", b, got, e); end
    if (err_frame !== m_frm) begin fails++; $display("FAIL tmo_nofrm: got %b expected %b", err_frame, m_frm); end
  endtask

  task automatic test_overrun();
    logic [7:0] b, e;
    logic got, tv;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), odd_par(8'(i)), 1'b1, -1);
    tests_run += 3;
    if (err_overrun !== m_ovr) begin fails++; $display("FAIL ovr_set: got %b expected %b", err_overrun, m_ovr); end
    if (ps2_clk_oe !== 1'b1) begin fails++; $display("FAIL ovr_oe: got %b expected 1", ps2_clk_oe); end
    if (out_data !== 8'h01) begin fails++; $display("FAIL ovr_head: got %h expected 01", out_data); end
    consume(b, got, tv);
    e = exp_q.pop_front();
    wait_cyc(3);
    tests_run += 2;
    if (got !== 1'b1 || b !== e) begin fails++; $display("FAIL ovr_pop: got %h expected %h", b, e); end
    if (ps2_clk_oe !== 1'b0) begin fails++; $display("FAIL ovr_oe_rel: got %b expected 0", ps2_clk_oe); end
    while (exp_q.size() > 0) begin
      consume(b, got, tv);
      e = exp_q.pop_front();
      tests_run++;
      if (got !== 1'b1 || b !== e || tv !== 1'b0) begin
        fails++; $display("FAIL ovr_order: got %h/%b/%b expected %h/1/0", b, got, tv, e);
      end
    end
    clear_errs();
  endtask

  task automatic test_glitch();
    logic [7:0] b, e;
    logic got, tv;
    send_frame(8'h5A, odd_par(8'h5A), 1'b1, 3);
    consume(b, got, tv);
    e = exp_q.pop_front();
    tests_run += 3;
    if (got !== 1'b1 || b !== e) begin fails++; $display("FAIL glitch_data: got %h/%b expected %h/1", b, got, e); end
    if (err_parity !== m_par) begin fails++; $display("FAIL glitch_par: got %b expected %b", err_parity, m_par); end
    if (err_frame !== m_frm) begin fails++; $display("FAIL glitch_frm: got %b expected %b", err_frame, m_frm); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b, e;
    logic got, tv;
    send_frame(8'hE0, odd_par(8'hE0), 1'b1, -1);
    send_frame(8'h75, odd_par(8'h75), 1'b1, -1);
    for (int k = 0; k < 2; k++) begin
      consume(b, got, tv);
      e = exp_q.pop_front();
      tests_run++;
      if (got !== 1'b1 || b !== e || tv !== 1'b0) begin
        fails++; $display("FAIL b2b_%0d: got %h/%b/%b expected %h/1/0", k, b, got, tv, e);
      end
    end
    wait_cyc(20);
    tests_run++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_empty: got %b expected 0", out_valid); end
  endtask

  task automatic test_random();
    logic [7:0] b, e, d;
    logic got, tv, par, stop;
    for (int it = 0; it < 10; it++) begin
      d    = 8'($urandom);
      par  = odd_par(d) ^ ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 5) != 0);
      send_frame(d, par, stop, -1);
      tests_run += 3;
      if (err_parity !== m_par) begin fails++; $display("FAIL rnd_par %0d: got %b expected %b", it, err_parity, m_par); end
      if (err_frame !== m_frm) begin fails++; $display("FAIL rnd_frm %0d: got %b expected %b", it, err_frame, m_frm); end
      if (err_overrun !== m_ovr) begin fails++; $display("FAIL rnd_ovr %0d: got %b expected %b", it, err_overrun, m_ovr); end
      while (exp_q.size() > 0) begin
        consume(b, got, tv);
        e = exp_q.pop_front();
        tests_run++;
        if (got !== 1'b1 || b !== e) begin fails++; $display("FAIL rnd_data %0d: got %h/%b expected %h/1", it, b, got, e); end
      end
      wait_cyc(5);
      tests_run++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL rnd_empty %0d: got %b expected 0", it, out_valid); end
      clear_errs();
    end
  endtask

  task automatic test_reset_midframe();
    send_frame(8'h33, odd_par(8'h33), 1'b1, -1);
    send_bits(11'b000_0101_0100, 5, -1);
    reset_n = 1'b0;
    wait_cyc(2);
    reset_n = 1'b1;
    exp_q.delete();
    wait_cyc(TMO + 50);
    tests_run += 3;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_valid: got %b expected 0", out_valid); end
    if (err_frame !== 1'b0) begin fails++; $display("FAIL mid_frm: got %b expected 0", err_frame); end
    if (err_parity !== 1'b0) begin fails++; $display("FAIL mid_par: got %b expected 0", err_parity); end
  endtask

  initial begin
    reset_n = 1'b0; ps2_clk_in = 1'b1; ps2_data_in = 1'b1; out_ready = 1'b0; err_clr = 1'b0;
    test_reset();
    test_frame_ok();
    test_parity_err();
    test_timeout();
    test_overrun();
    test_glitch();
    test_back_to_back();
    test_random();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
